alu_sequencer: RTL
==================

# alu_sequencer

Sequential front end that acts as the initiator for the 4-bit combinational ALU (add, subtract, AND, XOR). It debounces a pushbutton and snapshots the operand and opcode switches on each press. It then drives the ALU operand and select lines, waits a fixed settle time, and captures the result into an accumulator that feeds back as operand A. It sits between the board switches/key and the ALU, and replaces direct switch-to-ALU wiring with a chained accumulator machine.

## Interface
- SETTLE_CYCLES, 2: cycles operands are held before capture; 0 allowed.
- DEBOUNCE_BITS, 16: debounce counter width; the key must be stable for 2^DEBOUNCE_BITS cycles.
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- key_n  input  1  raw pushbutton, active-low, asynchronous to clk.
- sw  input  10  sw[3:0] operand B, sw[4] load mode, sw[7:5] unused, sw[9:8] opcode (00 add, 01 sub, 10 and, 11 xor).
- alu_a  output  4  ALU operand A (accumulator snapshot).
- alu_b  output  4  ALU operand B (latched sw[3:0]).
- alu_sel  output  2  ALU opcode (latched sw[9:8]).
- alu_result  input  4  combinational ALU result.
- led  output  10  led[3:0] accumulator, led[7:4] operation count mod 16, led[8] busy, led[9] accumulator zero.
- done  output  1  one-cycle pulse when the accumulator is written.

## Operation
- Key path: 2-flop synchronizer, then debouncer. The debounced level changes only after the synchronized input holds a new value for 2^DEBOUNCE_BITS consecutive cycles; any change restarts the count. A press event is a 1-cycle pulse on the debounced 1->0 transition. Release generates no event.
- FSM states: IDLE, ISSUE, SETTLE, CAPTURE.
- IDLE + press event, sw[4]=1: acc <= sw[3:0], done pulses, count unchanged, stay IDLE. No ALU transaction.
- IDLE + press event, sw[4]=0: latch B=sw[3:0] and sel=sw[9:8], latch A=acc, go to ISSUE.
- ISSUE: one cycle. Go to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
- SETTLE: exactly SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE: acc <= alu_result, count <= count+1 (4-bit wrap), done pulses, go to IDLE.
- alu_a/alu_b/alu_sel change only when latched in IDLE and hold through CAPTURE and afterwards. Switch changes after the press are ignored.
- Arithmetic is the ALU's. 4-bit modulo; no carry or borrow is kept. 8-9 = F.
- busy (led[8]) = 1 in ISSUE, SETTLE, CAPTURE. Press events while busy are discarded, not queued.
- led[9] = (acc == 0), combinational from the register.

## Timing
- Reset values: acc=0, count=0, alu_a=0, alu_b=0, alu_sel=00, done=0, led=10'b10_0000_0000, state IDLE, debounced level=1 (released), debounce counter 0.
- Raw key to press event: 2 sync cycles + 2^DEBOUNCE_BITS cycles + 1 cycle.
- Press event at cycle 0 (ALU op): ALU outputs valid from cycle 1. CAPTURE occurs at cycle SETTLE_CYCLES+2. The new acc and done are visible at cycle SETTLE_CYCLES+3. The next press is accepted from that cycle on.
- Load mode: acc and done are visible at cycle 1.
- Reset during any state aborts the operation: no capture, no done, all outputs return to reset values on the next edge.
- Press event coinciding with the CAPTURE cycle is discarded, because busy is still 1.

## Test plan
- Bench uses DEBOUNCE_BITS=2, SETTLE_CYCLES=2.
- Reset release -> led=0x200, alu_*=0, done=0. Load 5 (sw=0x015, press) -> led[3:0]=5, led[9]=0, count 0, done pulse 1 cycle after the event.
- acc=5, sw=0x003 add, press -> alu_a=5, alu_b=3, alu_sel=00 one cycle after the event; acc=8, count=1 exactly 5 cycles after the event. Toggling sw mid-op does not change alu_b.
- acc=8, sw=0x109 sub -> acc=F. Then sw=0x20C and -> acc=C. Then sw=0x30C xor -> acc=0, led[9]=1, count=3.
- Bounce: key_n low 3 cycles then high, repeated -> no press event, acc unchanged. Low held 6+ cycles -> exactly one event.
- Second press while busy -> ignored; count increments once. Assert rst_n=0 during SETTLE -> no done, acc=0, led=0x200 next cycle.
- SETTLE_CYCLES=0 build: add 1+1 -> acc=2 visible 3 cycles after the event.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// ALU operand/select bus between the sequencer and a combinational ALU.
// The sequencer is the master: it drives operands and reads the result.
interface alu_sequencer_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_result;

  modport master (
    output alu_a,
    output alu_b,
    output alu_sel,
    input  alu_result
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_sel,
    output alu_result
  );
endinterface

// File: rtl/alu_sequencer.sv
// Debounced-key front end that issues ops to a 4-bit ALU and
// accumulates the result, which feeds back as the next operand A.
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_n,
  input  logic [9:0]            sw,
  alu_sequencer_if.master       alu,
  output logic [9:0]            led,
  output logic                  done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam int SC_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST =
    SC_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic                     sync1_q, sync2_q;
  logic                     deb_q, deb_d;
  logic                     deb_prev_q;
  logic [DEBOUNCE_BITS-1:0] dcnt_q, dcnt_d;
  logic                     press_w;

  logic [1:0]      state_q, state_d;
  logic [SC_W-1:0] st_q, st_d;
  logic [3:0]      acc_q, acc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic [1:0]      sel_q, sel_d;
  logic            done_q, done_d;
  logic            busy_w;
  logic            unused_sw;

  assign unused_sw = ^sw[7:5];

  // Two-flop synchronizer for the asynchronous key (idles high).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Level follows the key only after 2^DEBOUNCE_BITS stable cycles.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == '1) begin
        deb_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  // Debounced level, its previous value and the stability counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      dcnt_q     <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
    end
  end

  assign press_w = deb_prev_q & ~deb_q;
  assign busy_w  = (state_q != S_IDLE);

  // Sequencer next-state: load, issue, settle and capture.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press_w) begin
          if (sw[4]) begin
            acc_d  = sw[3:0];
            done_d = 1'b1;
          end else begin
            a_d     = acc_q;
            b_d     = sw[3:0];
            sel_d   = sw[9:8];
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        st_d    = '0;
        state_d = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
      end
      S_SETTLE: begin
        if (st_q == SC_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          st_d = st_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        acc_d   = alu.alu_result;
        cnt_d   = cnt_q + 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign alu.alu_a   = a_q;
  assign alu.alu_b   = b_q;
  assign alu.alu_sel = sel_q;
  assign done        = done_q;
  assign led         = {(acc_q == 4'd0), busy_w, cnt_q, acc_q};

endmodule
